// File: rtl/rbm_sequencer_pkg.sv
// rtl/rbm_sequencer_pkg.sv - shared defaults, address widths and state encoding for the RBM sequencer
package rbm_sequencer_pkg;

  // Default network geometry and datapath widths
  localparam int DEF_N_PIXEL  = 784;
  localparam int DEF_N_HIDDEN = 441;
  localparam int DEF_N_CLASS  = 10;
  localparam int DEF_W_W      = 12;
  localparam int DEF_CNT_W    = 8;

  // Fixed address port widths toward the weight/bias/image memories
  localparam int IMG_AW = 10;
  localparam int HID_AW = 9;
  localparam int CLS_AW = 4;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HID  = 3'd1,
    S_CLS  = 3'd2,
    S_ARG  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

endpackage

// File: rtl/rbm_sequencer_if.sv
// rtl/rbm_sequencer_if.sv - control, memory-read and datapath signals between sequencer and RBM datapath
interface rbm_sequencer_if
  import rbm_sequencer_pkg::*;
#(
  parameter int W_W     = DEF_W_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int N_CLASS = DEF_N_CLASS
) ();

  // Run control
  logic                     start;
  logic [CNT_W-1:0]         iter_num;
  logic                     busy;
  logic                     done;

  // Memory addresses and read data
  logic [IMG_AW-1:0]        img_addr;
  logic                     img_bit;
  logic [HID_AW-1:0]        hid_addr;
  logic [W_W-1:0]           hw_data;
  logic [W_W-1:0]           hb_data;
  logic [CLS_AW-1:0]        cls_addr;
  logic [W_W-1:0]           cw_data;
  logic [W_W-1:0]           cb_data;
  logic                     sw_bit;

  // Datapath operands and sampled results
  logic                     enable_hidden;
  logic                     enable_classi;
  logic [IMG_AW-1:0]        pixel_id;
  logic [HID_AW-1:0]        hidden_id;
  logic [W_W-1:0]           Hvalue;
  logic                     pixel;
  logic                     HiddenSwitch;
  logic [W_W-1:0]           Cvalue;
  logic                     hidden_pixel;
  logic                     hidden;
  logic                     spike;

  // Run results
  logic [N_CLASS*CNT_W-1:0] spike_cnt;
  logic [CLS_AW-1:0]        best_class;

  modport master (
    input  start, iter_num, img_bit, hw_data, hb_data, cw_data, cb_data, sw_bit, hidden, spike,
    output busy, done, img_addr, hid_addr, cls_addr, enable_hidden, enable_classi, pixel_id,
           hidden_id, Hvalue, pixel, HiddenSwitch, Cvalue, hidden_pixel, spike_cnt, best_class
  );

  modport slave (
    output start, iter_num, img_bit, hw_data, hb_data, cw_data, cb_data, sw_bit, hidden, spike,
    input  busy, done, img_addr, hid_addr, cls_addr, enable_hidden, enable_classi, pixel_id,
           hidden_id, Hvalue, pixel, HiddenSwitch, Cvalue, hidden_pixel, spike_cnt, best_class
  );

endinterface

// File: rtl/rbm_sequencer_argmax.sv
// rtl/rbm_sequencer_argmax.sv - sequential one-element-per-cycle argmax scan over N packed counts
module rbm_argmax
  import rbm_sequencer_pkg::*;
#(
  parameter int N = DEF_N_CLASS,
  parameter int W = DEF_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_i,
  input  logic [N*W-1:0]    vals_i,
  output logic              valid_o,
  output logic [CLS_AW-1:0] idx_o
);

  localparam logic [CLS_AW-1:0] K_LAST = CLS_AW'(N - 1);

  logic              act_q;
  logic [CLS_AW-1:0] k_q;
  logic [CLS_AW-1:0] bi_q;
  logic [W-1:0]      bv_q;

  logic [CLS_AW-1:0] cur_k;
  logic [W-1:0]      cur_v;
  logic              take;
  logic [CLS_AW-1:0] bi_d;
  logic [W-1:0]      bv_d;

  // Element 0 is consumed in the start cycle; strict compare keeps the lowest index on ties
  always_comb begin
    cur_k = start_i ? '0 : k_q;
    cur_v = '0;
    for (int i = 0; i < N; i++) begin
      if (cur_k == CLS_AW'(i)) cur_v = vals_i[i*W +: W];
    end
    take = start_i || (cur_v > bv_q);
    bv_d = take ? cur_v : bv_q;
    bi_d = take ? cur_k : bi_q;
  end

  // The winner including the element compared this cycle is presented with valid on the last element
  assign valid_o = (start_i || act_q) && (cur_k == K_LAST);
  assign idx_o   = bi_d;

  // Scan state: running best value/index and element pointer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      act_q <= 1'b0;
      k_q   <= '0;
      bi_q  <= '0;
      bv_q  <= '0;
    end else if (start_i) begin
      act_q <= (K_LAST != '0);
      k_q   <= CLS_AW'(1);
      bi_q  <= bi_d;
      bv_q  <= bv_d;
    end else if (act_q) begin
      k_q  <= k_q + 1'b1;
      bi_q <= bi_d;
      bv_q <= bv_d;
      if (k_q == K_LAST) act_q <= 1'b0;
    end
  end

endmodule

// File: rtl/rbm_sequencer.sv
// rtl/rbm_sequencer.sv - iterates the RBM datapath through hidden/classifier phases and reports the argmax class
module rbm_sequencer
  import rbm_sequencer_pkg::*;
#(
  parameter int N_PIXEL  = DEF_N_PIXEL,
  parameter int N_HIDDEN = DEF_N_HIDDEN,
  parameter int N_CLASS  = DEF_N_CLASS,
  parameter int W_W      = DEF_W_W,
  parameter int CNT_W    = DEF_CNT_W
) (
  input logic           clock,
  input logic           reset,
  rbm_sequencer_if.master bus
);

  localparam logic [IMG_AW-1:0] P_BIAS  = IMG_AW'(N_PIXEL);
  localparam logic [IMG_AW-1:0] P_CAP   = IMG_AW'(N_PIXEL + 1);
  localparam logic [HID_AW-1:0] H_LAST  = HID_AW'(N_HIDDEN - 1);
  localparam logic [HID_AW-1:0] Q_BIAS  = HID_AW'(N_HIDDEN);
  localparam logic [HID_AW-1:0] Q_CAP   = HID_AW'(N_HIDDEN + 1);
  localparam logic [CLS_AW-1:0] C_LAST  = CLS_AW'(N_CLASS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  state_t                   state_q;
  logic [IMG_AW-1:0]        p_q;
  logic [HID_AW-1:0]        h_q;
  logic [HID_AW-1:0]        q_q;
  logic [CLS_AW-1:0]        c_q;
  logic [CNT_W-1:0]         iter_q;
  logic [CNT_W-1:0]         it_q;
  logic [N_HIDDEN-1:0]      hreg_q;
  logic [CNT_W-1:0]         cnt_q [N_CLASS];
  logic [CLS_AW-1:0]        best_q;
  logic                     arg_go_q;

  logic                     hbit_d;
  logic [CNT_W-1:0]         cur_cnt;
  logic [CNT_W-1:0]         cnt_sat_d;
  logic [N_CLASS*CNT_W-1:0] cnt_flat;
  logic                     arg_valid;
  logic [CLS_AW-1:0]        arg_idx;

  logic [IMG_AW-1:0]        img_addr_mx;
  logic [HID_AW-1:0]        hid_addr_mx;
  logic [CLS_AW-1:0]        cls_addr_mx;
  logic                     pixel_mx;
  logic [W_W-1:0]           hvalue_mx;
  logic                     sw_mx;
  logic                     hp_mx;
  logic [W_W-1:0]           cvalue_mx;

  // Stored hidden bit for the current classifier row and the saturated next count of the current class
  always_comb begin
    hbit_d  = 1'b0;
    cur_cnt = '0;
    for (int i = 0; i < N_HIDDEN; i++) begin
      if (q_q == HID_AW'(i)) hbit_d = hreg_q[i];
    end
    for (int i = 0; i < N_CLASS; i++) begin
      if (c_q == CLS_AW'(i)) cur_cnt = cnt_q[i];
    end
    cnt_sat_d = (bus.spike && (cur_cnt != CNT_MAX)) ? cur_cnt + 1'b1 : cur_cnt;
  end

  // Flatten counts for the output port and the argmax scan, class 0 in the LSBs
  always_comb begin
    cnt_flat = '0;
    for (int i = 0; i < N_CLASS; i++) cnt_flat[i*CNT_W +: CNT_W] = cnt_q[i];
  end

  rbm_argmax #(
    .N (N_CLASS),
    .W (CNT_W)
  ) u_argmax (
    .clock   (clock),
    .reset   (reset),
    .start_i (arg_go_q),
    .vals_i  (cnt_flat),
    .valid_o (arg_valid),
    .idx_o   (arg_idx)
  );

  // Run sequencing: phase counters, hidden capture, spike accumulation and argmax hand-off
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      p_q      <= '0;
      h_q      <= '0;
      q_q      <= '0;
      c_q      <= '0;
      iter_q   <= '0;
      it_q     <= '0;
      hreg_q   <= '0;
      best_q   <= '0;
      arg_go_q <= 1'b0;
      for (int i = 0; i < N_CLASS; i++) cnt_q[i] <= '0;
    end else begin
      arg_go_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            iter_q <= bus.iter_num;
            it_q   <= '0;
            best_q <= '0;
            p_q    <= '0;
            h_q    <= '0;
            q_q    <= '0;
            c_q    <= '0;
            for (int i = 0; i < N_CLASS; i++) cnt_q[i] <= '0;
            if (bus.iter_num != '0) begin
              state_q <= S_HID;
            end else begin
              state_q  <= S_ARG;
              arg_go_q <= 1'b1;
            end
          end
        end
        S_HID: begin
          if (p_q == P_CAP) begin
            for (int i = 0; i < N_HIDDEN; i++) begin
              if (h_q == HID_AW'(i)) hreg_q[i] <= bus.hidden;
            end
            p_q <= '0;
            if (h_q == H_LAST) begin
              h_q     <= '0;
              q_q     <= '0;
              c_q     <= '0;
              state_q <= S_CLS;
            end else begin
              h_q <= h_q + 1'b1;
            end
          end else begin
            p_q <= p_q + 1'b1;
          end
        end
        S_CLS: begin
          if (q_q == Q_CAP) begin
            for (int i = 0; i < N_CLASS; i++) begin
              if (c_q == CLS_AW'(i)) cnt_q[i] <= cnt_sat_d;
            end
            q_q <= '0;
            if (c_q == C_LAST) begin
              c_q  <= '0;
              it_q <= it_q + 1'b1;
              if (it_q + 1'b1 == iter_q) begin
                state_q  <= S_ARG;
                arg_go_q <= 1'b1;
              end else begin
                p_q     <= '0;
                h_q     <= '0;
                state_q <= S_HID;
              end
            end else begin
              c_q <= c_q + 1'b1;
            end
          end else begin
            q_q <= q_q + 1'b1;
          end
        end
        S_ARG: begin
          if (arg_valid) begin
            best_q  <= arg_idx;
            state_q <= S_FIN;
          end
        end
        S_FIN:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Address generation and operand muxing; everything is zero outside its active phase
  always_comb begin
    img_addr_mx = '0;
    hid_addr_mx = '0;
    cls_addr_mx = '0;
    pixel_mx    = 1'b0;
    hvalue_mx   = {W_W{1'b0}};
    sw_mx       = 1'b0;
    hp_mx       = 1'b0;
    cvalue_mx   = {W_W{1'b0}};
    if (state_q == S_HID) begin
      hid_addr_mx = h_q;
      sw_mx       = bus.sw_bit;
      if (p_q < P_BIAS) begin
        img_addr_mx = p_q;
        pixel_mx    = bus.img_bit;
        hvalue_mx   = bus.hw_data;
      end else if (p_q == P_BIAS) begin
        pixel_mx  = 1'b1;
        hvalue_mx = bus.hb_data;
      end
    end else if (state_q == S_CLS) begin
      hid_addr_mx = q_q;
      cls_addr_mx = c_q;
      if (q_q < Q_BIAS) begin
        hp_mx     = hbit_d;
        cvalue_mx = bus.cw_data;
      end else if (q_q == Q_BIAS) begin
        hp_mx     = 1'b1;
        cvalue_mx = bus.cb_data;
      end
    end
  end

  assign bus.busy          = (state_q == S_HID) || (state_q == S_CLS) || (state_q == S_ARG);
  assign bus.done          = (state_q == S_FIN);
  assign bus.enable_hidden = (state_q == S_HID);
  assign bus.enable_classi = (state_q == S_CLS);
  assign bus.img_addr      = img_addr_mx;
  assign bus.pixel_id      = img_addr_mx;
  assign bus.hid_addr      = hid_addr_mx;
  assign bus.hidden_id     = hid_addr_mx;
  assign bus.cls_addr      = cls_addr_mx;
  assign bus.pixel         = pixel_mx;
  assign bus.Hvalue        = hvalue_mx;
  assign bus.HiddenSwitch  = sw_mx;
  assign bus.hidden_pixel  = hp_mx;
  assign bus.Cvalue        = cvalue_mx;
  assign bus.spike_cnt     = cnt_flat;
  assign bus.best_class    = best_q;

endmodule

// File: doc/rbm_sequencer.md
Name: rbm_sequencer

Overview:
Synthesizable controller that sequences the stochastic RBM datapath (`Main`) through repeated inference iterations. The sequencing currently lives in bench code; this block replaces it.
- Generates weight, bias, image and switch addresses, and muxes operands into the datapath.
- Drives `enable_hidden` and `enable_classi`.
- Stores sampled hidden bits and accumulates per-class spike counts.
- Reports the argmax class after a run-time number of iterations.

Parameters:
N_PIXEL, 784, visible units per image
N_HIDDEN, 441, hidden units
N_CLASS, 10, classifier outputs
W_W, 12, weight/bias word width
CNT_W, 8, per-class spike counter width (saturating)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  pulse; begins a run when idle
iter_num  in  CNT_W  iterations per run; latched on accepted start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at run end
img_addr  out  10  image bit / hidden-weight pixel address
img_bit  in  1  image bit (combinational read)
hid_addr  out  9  hidden index: hidden weight/bias, switch, classifier weight row
hw_data  in  W_W  hidden weight[img_addr][hid_addr]
hb_data  in  W_W  hidden bias[hid_addr]
cls_addr  out  4  class index for classifier weight/bias
cw_data  in  W_W  classifier weight[hid_addr][cls_addr]
cb_data  in  W_W  classifier bias[cls_addr]
sw_bit  in  1  criticality switch bit[hid_addr]
enable_hidden  out  1  datapath hidden phase
enable_classi  out  1  datapath classifier phase
pixel_id  out  10  = img_addr
hidden_id  out  9  = hid_addr
Hvalue  out  W_W  hidden operand
pixel  out  1  hidden input bit
HiddenSwitch  out  1  = sw_bit, passed through
Cvalue  out  W_W  classifier operand
hidden_pixel  out  1  classifier input bit
hidden  in  1  sampled hidden output
spike  in  1  sampled class spike
spike_cnt  out  N_CLASS*CNT_W  packed counts, class 0 in LSBs
best_class  out  4  argmax of counts

Behaviour:
- Reset values:
  - State IDLE; all addresses, operands, enables, busy and done are 0.
  - spike_cnt and best_class are 0.
  - Hidden register file is cleared.
  - Reset mid-run aborts immediately; no done pulse.
- States: IDLE, HID, CLS, ARG, FIN.
  - enable_hidden is 1 only in HID.
  - enable_classi is 1 only in CLS.
  - The two enables are never high together.
- IDLE:
  - On start, latch iter_num, clear counts and best_class, set busy.
  - If iter_num≠0, enter HID with p=0, h=0.
  - If iter_num=0, enter ARG.
  - start outside IDLE is ignored.
- HID: phase counter p runs 0..N_PIXEL+1 per hidden unit h.
  - p<N_PIXEL: img_addr=p, pixel=img_bit, Hvalue=hw_data.
  - p=N_PIXEL: pixel=1, Hvalue=hb_data.
  - p=N_PIXEL+1: capture hreg[h]<=hidden.
    - If h<N_HIDDEN-1: h++, p=0.
    - Otherwise: h=0, q=0, c=0, enter CLS the next cycle with no gap.
- CLS: phase counter q runs 0..N_HIDDEN+1 per class c; hid_addr=q.
  - q<N_HIDDEN: hidden_pixel=hreg[q], Cvalue=cw_data.
  - q=N_HIDDEN: hidden_pixel=1, Cvalue=cb_data.
  - q=N_HIDDEN+1: cnt[c]<=min(cnt[c]+spike, 2^CNT_W-1).
    - If c<N_CLASS-1: c++, q=0.
    - Otherwise: it++. If it==iter_num, enter ARG; else enter HID with p=h=0.
- Cycles per iteration: N_HIDDEN*(N_PIXEL+2)+N_CLASS*(N_HIDDEN+2), which is 351056 at defaults.
- ARG:
  - Sequential scan over N_CLASS cycles.
  - Strictly-greater compare, so ties resolve to the lower index.
  - best_class is written at scan end; then enter FIN.
- FIN:
  - done=1 for one cycle, busy drops in the same cycle, return to IDLE.
  - Counts and best_class hold until the next accepted start.
- Operand outputs are 0 outside the active phase.
- The hidden register file persists across iterations; every entry is rewritten each iteration before CLS reads it.

Decomposition:
- Shared package (config header): N_PIXEL/N_HIDDEN/N_CLASS/W_W/CNT_W defaults and the state encoding.
- Sub-module rbm_argmax: sequential N-way max scan with start/valid handshake.

Test Plan:
1. Setup for scenarios 1–4: N_PIXEL=4, N_HIDDEN=3, N_CLASS=2, stub datapath with hidden=1 and spike=1, iter_num=3, start. Required: done exactly 3*(3*6+2*5)=84 cycles after start, plus 2 ARG cycles and 1 FIN cycle; cnt={3,3}; best_class=0 (tie → lower index).
2. Same setup, spike=(cls_addr==1). Required: cnt0=0, cnt1=3, best_class=1. Check that Hvalue=hb_data and pixel=1 exactly at p=4, and that hidden_pixel=1 with Cvalue=cb_data at q=3.
3. Stub hidden=hid_addr[0] (unit-dependent). Required: hidden_pixel in CLS reads 0,1,0 for q=0..2; enable_hidden and enable_classi are never simultaneously high; no idle cycle at the HID→CLS handoff.
4. CNT_W=2, iter_num=3, then 5 (wraps to 1 in 2 bits), spike=1. Required: counts saturate at 3, never wrap; iter_num=0 start gives done after N_CLASS+1 cycles with all counts 0.
5. Assert reset mid-CLS. Required: all outputs 0 asynchronously; no done; a subsequent start runs the full latency from zero. A start pulse while busy has no effect.
